// File: rtl/usr_pkg.sv
// Shared types and helpers for the push-button universal shift register front panel.
package usr_pkg;

   typedef enum logic [1:0] {
      USR_HOLD = 2'b00,
      USR_SHR  = 2'b01,
      USR_SHL  = 2'b10,
      USR_LOAD = 2'b11
   } usr_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } step_state_t;

   function automatic usr_op_t next_op(usr_op_t op);
      logic [1:0] v;
      v = op + 2'd1;
      return usr_op_t'(v);
   endfunction

   // True when a w-bit counter can reach n.
   function automatic bit cnt_fits(int unsigned w, int unsigned n);
      return (w >= 32) || ((64'd1 << w) > 64'(n));
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stability-counter debounce, with a one-cycle
// accept pulse on the rising edge of the debounced level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic level_o,
   output logic accept_o
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             accept_q, accept_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         accept_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         level_q  <= level_d;
         accept_q <= accept_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      level_d  = level_q;
      accept_d = 1'b0;
      cnt_d    = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d  = ~level_q;
            accept_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign level_o  = level_q;
   assign accept_o = accept_q;

endmodule

// File: rtl/usr_step_ctrl.sv
// Front-panel step controller: debounced step/mode buttons drive en, s and d of the
// universal shift register. Define USR_STEP_AUTO_REPEAT_EN for hold-to-repeat stepping.
module usr_step_ctrl
   import usr_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_CYCLES   = 25000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_step_i,
   input  logic       btn_mode_i,
   input  logic       sw_d_i,
   output logic       en_o,
   output logic [1:0] s_o,
   output logic       d_o
);

   if (!cnt_fits(CNT_W, DEBOUNCE_CYCLES) || !cnt_fits(CNT_W, REPEAT_CYCLES)) begin : g_cnt_w_chk
      $error("CNT_W too narrow for DEBOUNCE_CYCLES/REPEAT_CYCLES");
   end

   logic        step_level, step_accept;
   logic        mode_accept, mode_level_unused;
   logic        sw_sync1_q, sw_sync2_q;
   step_state_t state_q, state_d;
   logic        en_q, en_d;
   logic        d_q, d_d;
   usr_op_t     s_q, s_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_step_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_step_i),
      .level_o (step_level),
      .accept_o(step_accept)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_mode_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_mode_i),
      .level_o (mode_level_unused),
      .accept_o(mode_accept)
   );

`ifdef USR_STEP_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RptLast = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] rpt_q, rpt_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_sync1_q <= 1'b0;
         sw_sync2_q <= 1'b0;
         state_q    <= IDLE;
         en_q       <= 1'b0;
         d_q        <= 1'b0;
         s_q        <= USR_HOLD;
      end else begin
         sw_sync1_q <= sw_d_i;
         sw_sync2_q <= sw_sync1_q;
         state_q    <= state_d;
         en_q       <= en_d;
         d_q        <= d_d;
         s_q        <= s_d;
      end
   end

   always_comb begin
      state_d = state_q;
      en_d    = 1'b0;
`ifdef USR_STEP_AUTO_REPEAT_EN
      rpt_d   = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (step_accept) begin
               en_d    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Release wins over a repeat pulse falling due on the same cycle.
            if (!step_level) begin
               state_d = IDLE;
            end
`ifdef USR_STEP_AUTO_REPEAT_EN
            else if (rpt_q == RptLast) begin
               en_d = 1'b1;
            end else begin
               rpt_d = rpt_q + CNT_W'(1);
            end
`endif
         end
      endcase
   end

   assign s_d = mode_accept ? next_op(s_q) : s_q;
   assign d_d = en_d ? sw_sync2_q : d_q;

   assign en_o = en_q;
   assign s_o  = s_q;
   assign d_o  = d_q;

endmodule

// File: tb/tb_usr_step_ctrl.sv
// Randomised bench for usr_step_ctrl with a cycle-level behavioural model and a few
// hand-computed scenario checks.
module tb_usr_step_ctrl;
   import usr_pkg::*;

   localparam int unsigned DEB = 4;
   localparam int unsigned RPT = 8;
   localparam int unsigned CW  = 4;
`ifdef USR_STEP_AUTO_REPEAT_EN
   localparam int ExpLong   = 2;
   localparam int ExpRepeat = 5;
`else
   localparam int ExpLong   = 1;
   localparam int ExpRepeat = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_step = 1'b0, btn_mode = 1'b0, sw_d = 1'b0;
   logic       en;
   logic [1:0] s;
   logic       d;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   usr_step_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (RPT),
      .CNT_W          (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_step_i(btn_step),
      .btn_mode_i(btn_mode),
      .sw_d_i    (sw_d),
      .en_o      (en),
      .s_o       (s),
      .d_o       (d)
   );

   // Model state
   int         cyc = 0;
   bit         m_valid = 0;
   logic [1:0] dl_step = '0, dl_mode = '0, dl_sw = '0;
   logic       lvl_step = 0, lvl_mode = 0, acc_step = 0, acc_mode = 0;
   int         run_step = 0, run_mode = 0;
   bit         m_hold = 0;
   int         last_en = 0;
   logic       m_en = 0, m_d = 0;
   int         m_s = 0;

   // Observations of the DUT
   int         en_cnt = 0, en_cyc = 0;
   logic       en_d_val = 0;
   logic [1:0] en_s_val = '0, s_before_en = '0, prev_s = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Level is accepted after DEB consecutive cycles of disagreement with the synced input.
   task automatic deb(input logic seen, inout logic lvl, inout int run, output logic acc);
      acc = 1'b0;
      if (seen != lvl) run++;
      else run = 0;
      if (run == int'(DEB)) begin
         lvl = ~lvl;
         run = 0;
         acc = lvl;
      end
   endtask

   initial begin : model
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset) begin
            dl_step = '0; dl_mode = '0; dl_sw = '0;
            lvl_step = 0; lvl_mode = 0; acc_step = 0; acc_mode = 0;
            run_step = 0; run_mode = 0;
            m_hold = 0; m_en = 0; m_s = 0; m_d = 0;
         end else begin
            m_en = 1'b0;
            if (!m_hold) begin
               if (acc_step) begin
                  m_en   = 1'b1;
                  m_hold = 1'b1;
               end
            end else if (!lvl_step) begin
               m_hold = 1'b0;
            end
`ifdef USR_STEP_AUTO_REPEAT_EN
            else if (cyc - last_en == int'(RPT)) begin
               m_en = 1'b1;
            end
`endif
            if (m_en) begin
               last_en = cyc;
               m_d     = dl_sw[1];
            end
            if (acc_mode) m_s = (m_s + 1) % 4;
            deb(dl_step[1], lvl_step, run_step, acc_step);
            deb(dl_mode[1], lvl_mode, run_mode, acc_mode);
            dl_step = {dl_step[0], btn_step};
            dl_mode = {dl_mode[0], btn_mode};
            dl_sw   = {dl_sw[0], sw_d};
         end
         m_valid = 1;
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("en", {31'b0, en}, {31'b0, m_en});
            check("s", {30'b0, s}, m_s);
            check("d", {31'b0, d}, {31'b0, m_d});
            if (en === 1'b1) begin
               en_cnt++;
               en_cyc      = cyc;
               en_d_val    = d;
               en_s_val    = s;
               s_before_en = prev_s;
            end
            prev_s = s;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [1:0] mode_seq [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

   initial begin : stim
      int base;
      int rise_cyc;

      // Reset held with buttons wiggling
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         btn_step = i[0];
         btn_mode = ~i[0];
         sw_d     = 1'b1;
         tick(1);
         check("rst_en", {31'b0, en}, 0);
         check("rst_s", {30'b0, s}, 0);
         check("rst_d", {31'b0, d}, 0);
      end
      btn_step = 0; btn_mode = 0; sw_d = 0;
      reset = 1'b1;
      tick(10);
      check("post_rst_en_cnt", en_cnt, 0);
      check("post_rst_s", {30'b0, s}, 0);

      // Bounce rejection, then a real press
      base = en_cnt;
      btn_step = 1; tick(3);
      btn_step = 0; tick(2);
      btn_step = 1; tick(3);
      btn_step = 0; tick(10);
      check("bounce_no_en", en_cnt - base, 0);
      btn_step = 1;
      rise_cyc = cyc;
      tick(10);
      btn_step = 0;
      tick(14);
      check("long_press_cnt", en_cnt - base, ExpLong);
      if (ExpLong == 1) check("latency", en_cyc - rise_cyc, 7);
      else check("latency", en_cyc - rise_cyc, 7 + RPT);

      // Mode wrap
      base = en_cnt;
      for (int i = 0; i < 5; i++) begin
         btn_mode = 1; tick(6);
         btn_mode = 0; tick(10);
         check("mode_seq", {30'b0, s}, {30'b0, mode_seq[i]});
      end
      check("mode_no_en", en_cnt - base, 0);

      // Data capture
      sw_d = 1; tick(3);
      base = en_cnt;
      btn_step = 1; tick(6);
      btn_step = 0; tick(10);
      check("data_press_cnt", en_cnt - base, 1);
      check("data_d1", {31'b0, en_d_val}, 1);
      sw_d = 0; tick(10);
      check("data_hold", {31'b0, d}, 1);
      btn_step = 1; tick(6);
      btn_step = 0; tick(10);
      check("data_d0", {31'b0, en_d_val}, 0);

      // Hold to repeat
      base = en_cnt;
      btn_step = 1; tick(40);
      btn_step = 0; tick(20);
      check("repeat_cnt", en_cnt - base, ExpRepeat);

      // Simultaneous mode and step press with s=01
      btn_mode = 1; btn_step = 1; tick(6);
      btn_mode = 0; btn_step = 0; tick(12);
      check("simul_s_at_en", {30'b0, en_s_val}, 2);
      check("simul_s_before", {30'b0, s_before_en}, 1);

      // Reset in HOLD
      btn_step = 1; tick(9);
      reset = 1'b0; tick(1);
      check("rst_hold_en", {31'b0, en}, 0);
      check("rst_hold_fsm", {31'b0, dut.state_q}, {31'b0, IDLE});
      check("rst_hold_s", {30'b0, s}, 0);
      reset = 1'b1; tick(4);
      btn_step = 0; tick(15);

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         btn_step = 1'($urandom_range(0, 1));
         btn_mode = 1'($urandom_range(0, 1));
         sw_d     = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b0;
            tick($urandom_range(1, 2));
            reset = 1'b1;
         end
         tick($urandom_range(1, 12));
      end
      btn_step = 0; btn_mode = 0;
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
